// File: rtl/nibble_demux_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_demux_if
// Description : Nibble input bus and assembled-frame output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_demux_if;
    logic        in_valid;
    logic [1:0]  in_sel;
    logic [3:0]  in_data;
    logic [3:0]  out0;
    logic [3:0]  out1;
    logic [3:0]  out2;
    logic [3:0]  out3;
    logic [15:0] out_word;
    logic        frame_valid;
    logic        seq_error;
    logic        busy;

    modport master (
        output in_valid, in_sel, in_data,
        input  out0, out1, out2, out3, out_word, frame_valid, seq_error, busy
    );

    modport slave (
        input  in_valid, in_sel, in_data,
        output out0, out1, out2, out3, out_word, frame_valid, seq_error, busy
    );
endinterface
`default_nettype wire

// File: rtl/nibble_demux.sv
`default_nettype none
// ============================================================================
// Module      : nibble_demux
// Description : Collects four in-order nibbles into a registered 16-bit frame.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_demux #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  wire logic     clk_i,
    input  wire logic     rst_i,
    nibble_demux_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    localparam logic [1:0] c_LAST_IDX = 2'd3;

    state_t     state_q, state_d;
    logic [1:0] exp_q, exp_d;
    logic [3:0] s0_q, s0_d;
    logic [3:0] s1_q, s1_d;
    logic [3:0] s2_q, s2_d;
    logic [7:0] idle_q, idle_d;
    logic [3:0] out0_q, out0_d;
    logic [3:0] out1_q, out1_d;
    logic [3:0] out2_q, out2_d;
    logic [3:0] out3_q, out3_d;
    logic       fv_q, fv_d;
    logic       se_q, se_d;
    logic [7:0] w_idle_inc;

    // Saturate so a disabled timeout never wraps back into a false match.
    assign w_idle_inc = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            exp_q   <= 2'd0;
            s0_q    <= 4'd0;
            s1_q    <= 4'd0;
            s2_q    <= 4'd0;
            idle_q  <= 8'd0;
            out0_q  <= 4'd0;
            out1_q  <= 4'd0;
            out2_q  <= 4'd0;
            out3_q  <= 4'd0;
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            idle_q  <= idle_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            out2_q  <= out2_d;
            out3_q  <= out3_d;
            fv_q    <= fv_d;
            se_q    <= se_d;
        end
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        idle_d  = idle_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        out2_d  = out2_q;
        out3_d  = out3_q;
        fv_d    = 1'b0;
        se_d    = 1'b0;

        if (state_q == ST_IDLE) begin
            if (bus.in_valid) begin
                if (bus.in_sel == 2'd0) begin
                    s0_d    = bus.in_data;
                    exp_d   = 2'd1;
                    idle_d  = 8'd0;
                    state_d = ST_COLLECT;
                end else begin
                    se_d = 1'b1;
                end
            end
        end else begin
            if (bus.in_valid) begin
                if ((bus.in_sel == exp_q) && (exp_q != c_LAST_IDX)) begin
                    case (exp_q)
                        2'd0:    s0_d = bus.in_data;
                        2'd1:    s1_d = bus.in_data;
                        default: s2_d = bus.in_data;
                    endcase
                    exp_d  = exp_q + 2'd1;
                    idle_d = 8'd0;
                end else if ((bus.in_sel == c_LAST_IDX) && (exp_q == c_LAST_IDX)) begin
                    out0_d  = s0_q;
                    out1_d  = s1_q;
                    out2_d  = s2_q;
                    out3_d  = bus.in_data;
                    fv_d    = 1'b1;
                    exp_d   = 2'd0;
                    idle_d  = 8'd0;
                    state_d = ST_IDLE;
                end else if (bus.in_sel == 2'd0) begin
                    // A fresh slot 0 mid-frame is treated as the start of a new frame.
                    se_d   = 1'b1;
                    s0_d   = bus.in_data;
                    exp_d  = 2'd1;
                    idle_d = 8'd0;
                end else begin
                    se_d    = 1'b1;
                    exp_d   = 2'd0;
                    idle_d  = 8'd0;
                    state_d = ST_IDLE;
                end
            end else begin
                idle_d = w_idle_inc;
                if ((TIMEOUT_CYCLES != 8'd0) && (w_idle_inc == TIMEOUT_CYCLES)) begin
                    se_d    = 1'b1;
                    exp_d   = 2'd0;
                    idle_d  = 8'd0;
                    state_d = ST_IDLE;
                end
            end
        end
    end

    assign bus.out0        = out0_q;
    assign bus.out1        = out1_q;
    assign bus.out2        = out2_q;
    assign bus.out3        = out3_q;
    assign bus.out_word    = {out3_q, out2_q, out1_q, out0_q};
    assign bus.frame_valid = fv_q;
    assign bus.seq_error   = se_q;
    assign bus.busy        = (state_q == ST_COLLECT);

endmodule
`default_nettype wire

// File: tb/tb_nibble_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_demux
// Description : Directed self-checking bench for nibble_demux (timeout = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_demux;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    nibble_demux_if bus ();

    nibble_demux #(
        .TIMEOUT_CYCLES (8'd4)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of input at the falling edge, return at the next falling edge.
    task automatic nib(input logic v, input logic [1:0] s, input logic [3:0] d);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulses(input string tag, input logic fv, input logic se, input logic bsy);
        chk({tag, "_fv"},   {15'd0, bus.frame_valid}, {15'd0, fv});
        chk({tag, "_se"},   {15'd0, bus.seq_error},   {15'd0, se});
        chk({tag, "_busy"}, {15'd0, bus.busy},        {15'd0, bsy});
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        clk          = 1'b0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sel   = 2'd0;
        bus.in_data  = 4'd0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_word", bus.out_word, 16'h0000);
        pulses("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // In-order frame
        nib(1'b1, 2'd0, 4'hA);
        pulses("inord_n0", 1'b0, 1'b0, 1'b1);
        nib(1'b1, 2'd1, 4'hB);
        nib(1'b1, 2'd2, 4'hC);
        chk("inord_partial_word", bus.out_word, 16'h0000);
        nib(1'b1, 2'd3, 4'hD);
        pulses("inord_done", 1'b1, 1'b0, 1'b0);
        chk("inord_word", bus.out_word, 16'hDCBA);
        chk("inord_out3", {12'd0, bus.out3}, 16'h000D);
        nib(1'b0, 2'd0, 4'h0);
        pulses("inord_after", 1'b0, 1'b0, 1'b0);

        // Out-of-order start
        nib(1'b1, 2'd2, 4'h5);
        pulses("ooo_start", 1'b0, 1'b1, 1'b0);
        chk("ooo_word", bus.out_word, 16'hDCBA);
        nib(1'b0, 2'd0, 4'h0);
        pulses("ooo_after", 1'b0, 1'b0, 1'b0);

        // Restart on a repeated slot 0
        nib(1'b1, 2'd0, 4'h1);
        nib(1'b1, 2'd1, 4'h2);
        nib(1'b1, 2'd0, 4'h3);
        pulses("restart_err", 1'b0, 1'b1, 1'b1);
        nib(1'b1, 2'd1, 4'h4);
        pulses("restart_n1", 1'b0, 1'b0, 1'b1);
        nib(1'b1, 2'd2, 4'h5);
        nib(1'b1, 2'd3, 4'h6);
        pulses("restart_done", 1'b1, 1'b0, 1'b0);
        chk("restart_word", bus.out_word, 16'h6543);

        // Other mismatch mid-frame aborts to idle
        nib(1'b1, 2'd0, 4'hF);
        nib(1'b1, 2'd2, 4'hE);
        pulses("skip_err", 1'b0, 1'b1, 1'b0);
        chk("skip_word", bus.out_word, 16'h6543);

        // Timeout after four idle cycles
        nib(1'b1, 2'd0, 4'h7);
        pulses("to_start", 1'b0, 1'b0, 1'b1);
        nib(1'b0, 2'd0, 4'h0);
        nib(1'b0, 2'd0, 4'h0);
        nib(1'b0, 2'd0, 4'h0);
        pulses("to_idle3", 1'b0, 1'b0, 1'b1);
        nib(1'b0, 2'd0, 4'h0);
        pulses("to_idle4", 1'b0, 1'b1, 1'b0);
        chk("to_word", bus.out_word, 16'h6543);
        nib(1'b0, 2'd0, 4'h0);
        pulses("to_after", 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-frame
        nib(1'b1, 2'd0, 4'h1);
        nib(1'b1, 2'd1, 4'h2);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid_async_word", bus.out_word, 16'h0000);
        pulses("rstmid_async", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        pulses("rstmid_held", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        nib(1'b1, 2'd0, 4'h9);
        nib(1'b1, 2'd1, 4'h8);
        nib(1'b1, 2'd2, 4'h7);
        nib(1'b1, 2'd3, 4'h6);
        pulses("rstmid_done", 1'b1, 1'b0, 1'b0);
        chk("rstmid_word", bus.out_word, 16'h6789);

        // Back-to-back frames
        nib(1'b1, 2'd0, 4'h1);
        nib(1'b1, 2'd1, 4'h2);
        nib(1'b1, 2'd2, 4'h3);
        nib(1'b1, 2'd3, 4'h4);
        pulses("b2b_f1", 1'b1, 1'b0, 1'b0);
        chk("b2b_word1", bus.out_word, 16'h4321);
        nib(1'b1, 2'd0, 4'h5);
        pulses("b2b_n4", 1'b0, 1'b0, 1'b1);
        nib(1'b1, 2'd1, 4'h6);
        nib(1'b1, 2'd2, 4'h7);
        chk("b2b_hold", bus.out_word, 16'h4321);
        nib(1'b1, 2'd3, 4'h8);
        pulses("b2b_f2", 1'b1, 1'b0, 1'b0);
        chk("b2b_word2", bus.out_word, 16'h8765);
        nib(1'b0, 2'd0, 4'h0);
        pulses("b2b_after", 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
